// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic feeder and the MAC array it drives.
package systolic_feeder_pkg;

    localparam int unsigned N          = 4;
    localparam int unsigned DW_DEF     = 4;
    localparam int unsigned FEED_STEPS = 2 * N - 1;
    localparam int unsigned T_W        = 3;
    localparam int unsigned IDX_W      = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/systolic_feeder_if.sv
// Control, matrix and skewed-stream bundle between a feeder and its requester/array.
interface systolic_feeder_if #(
    parameter int unsigned DW = systolic_feeder_pkg::DW_DEF
);

    localparam int unsigned MAT_W = systolic_feeder_pkg::N * systolic_feeder_pkg::N * DW;

    logic             start;
    logic [MAT_W-1:0] a_mat;
    logic [MAT_W-1:0] b_mat;
    logic [DW-1:0]    a_in_row0;
    logic [DW-1:0]    a_in_row1;
    logic [DW-1:0]    a_in_row2;
    logic [DW-1:0]    a_in_row3;
    logic [DW-1:0]    b_in_col0;
    logic [DW-1:0]    b_in_col1;
    logic [DW-1:0]    b_in_col2;
    logic [DW-1:0]    b_in_col3;
    logic             clr;
    logic [1:0]       enable;
    logic             update_ready;
    logic             busy;

    modport master (
        output start, a_mat, b_mat,
        input  a_in_row0, a_in_row1, a_in_row2, a_in_row3,
        input  b_in_col0, b_in_col1, b_in_col2, b_in_col3,
        input  clr, enable, update_ready, busy
    );

    modport slave (
        input  start, a_mat, b_mat,
        output a_in_row0, a_in_row1, a_in_row2, a_in_row3,
        output b_in_col0, b_in_col1, b_in_col2, b_in_col3,
        output clr, enable, update_ready, busy
    );

endinterface

// File: rtl/systolic_feeder_skew_select.sv
// Picks element (t - lane) of a latched row/column, or 0 outside the 4-wide skew window.
module skew_select
    import systolic_feeder_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic             en_i,
    input  logic [T_W-1:0]   t_i,
    input  logic [IDX_W-1:0] lane_i,
    input  logic [N*DW-1:0]  vec_i,
    output logic [DW-1:0]    elem_c_o
);

    localparam int unsigned D_W = T_W + 1;

    logic [D_W-1:0]   diff;
    logic [IDX_W-1:0] idx;
    logic             hit;

    // Extra sign bit on diff catches t < lane; upper bits catch t - lane > N-1.
    always_comb begin
        diff     = {1'b0, t_i} - D_W'(lane_i);
        idx      = diff[IDX_W-1:0];
        hit      = en_i && (diff[D_W-1:IDX_W] == '0);
        elem_c_o = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (hit && (idx == IDX_W'(k))) begin
                elem_c_o = vec_i[k*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Sequences clear/feed/drain/done for one 4x4 systolic product and emits skewed operand streams.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned DW           = DW_DEF
) (
    input logic          CLK,
    input logic          RST,
    systolic_feeder_if.slave bus
);

    localparam int unsigned MAT_W   = N * N * DW;
    localparam int unsigned CNT_MAX = (DRAIN_CYCLES > FEED_STEPS) ? DRAIN_CYCLES : FEED_STEPS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_STEPS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] t_q, t_d;
    logic [MAT_W-1:0] a_lat_q, a_lat_d;
    logic [MAT_W-1:0] b_lat_q, b_lat_d;
    logic             clr_q, clr_d;
    logic [1:0]       en_q, en_d;
    logic             upd_q, upd_d;
    logic             busy_q, busy_d;
    logic             feed_d;
    logic [DW-1:0]    a_row_q [N];
    logic [DW-1:0]    a_row_d [N];
    logic [DW-1:0]    b_col_q [N];
    logic [DW-1:0]    b_col_d [N];
    logic [N*DW-1:0]  a_vec   [N];
    logic [N*DW-1:0]  b_vec   [N];

    // Next state plus registered-output decode from the state being entered.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        a_lat_d = a_lat_q;
        b_lat_d = b_lat_q;
        clr_d   = 1'b0;
        en_d    = 2'b00;
        upd_d   = 1'b0;
        busy_d  = 1'b0;
        feed_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLEAR;
                    a_lat_d = bus.a_mat;
                    b_lat_d = bus.b_mat;
                end
            end
            CLEAR: begin
                state_d = FEED;
                t_d     = '0;
            end
            FEED: begin
                if (t_q == FEED_LAST) begin
                    state_d = DRAIN;
                    t_d     = '0;
                end else begin
                    t_d = t_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (t_q == DRAIN_LAST) begin
                    state_d = DONE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            CLEAR: begin
                clr_d  = 1'b1;
                busy_d = 1'b1;
            end
            FEED: begin
                en_d   = 2'b11;
                busy_d = 1'b1;
                feed_d = 1'b1;
            end
            DRAIN: begin
                en_d   = 2'b11;
                busy_d = 1'b1;
            end
            DONE: begin
                upd_d  = 1'b1;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Row i of A is contiguous; column j of B is strided by N elements.
    always_comb begin
        a_vec = '{default: '0};
        b_vec = '{default: '0};
        for (int r = 0; r < int'(N); r++) begin
            for (int k = 0; k < int'(N); k++) begin
                a_vec[r][k*DW +: DW] = a_lat_q[(int'(N)*r + k)*DW +: DW];
                b_vec[r][k*DW +: DW] = b_lat_q[(int'(N)*k + r)*DW +: DW];
            end
        end
    end

    for (genvar g = 0; g < int'(N); g++) begin : g_lane
        skew_select #(.DW(DW)) u_row (
            .en_i     (feed_d),
            .t_i      (T_W'(t_d)),
            .lane_i   (IDX_W'(g)),
            .vec_i    (a_vec[g]),
            .elem_c_o (a_row_d[g])
        );
        skew_select #(.DW(DW)) u_col (
            .en_i     (feed_d),
            .t_i      (T_W'(t_d)),
            .lane_i   (IDX_W'(g)),
            .vec_i    (b_vec[g]),
            .elem_c_o (b_col_d[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            t_q     <= '0;
            a_lat_q <= '0;
            b_lat_q <= '0;
            clr_q   <= 1'b0;
            en_q    <= 2'b00;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            a_row_q <= '{default: '0};
            b_col_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a_lat_q <= a_lat_d;
            b_lat_q <= b_lat_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
            a_row_q <= a_row_d;
            b_col_q <= b_col_d;
        end
    end

    assign bus.a_in_row0    = a_row_q[0];
    assign bus.a_in_row1    = a_row_q[1];
    assign bus.a_in_row2    = a_row_q[2];
    assign bus.a_in_row3    = a_row_q[3];
    assign bus.b_in_col0    = b_col_q[0];
    assign bus.b_in_col1    = b_col_q[1];
    assign bus.b_in_col2    = b_col_q[2];
    assign bus.b_in_col3    = b_col_q[3];
    assign bus.clr          = clr_q;
    assign bus.enable       = en_q;
    assign bus.update_ready = upd_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench: a run-level reference model queues expected output frames; a monitor compares.
module tb_systolic_feeder;

    localparam int unsigned DW      = 4;
    localparam int unsigned DRAIN   = 4;
    localparam int          RUN_LEN = 1 + 7 + int'(DRAIN) + 1;
    localparam int unsigned MAT_W   = 16 * DW;

    typedef struct packed {
        logic              clr;
        logic [1:0]        en;
        logic              upd;
        logic signed [3:0] step;
        logic [4*DW-1:0]   a;
        logic [4*DW-1:0]   b;
    } frame_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    systolic_feeder_if #(.DW(DW)) bus ();

    systolic_feeder #(.DRAIN_CYCLES(DRAIN), .DW(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int     n_vec = 0;
    int     n_err = 0;
    int     cyc   = 0;
    bit     mon_on = 1'b0;
    int     model_cnt = 0;
    frame_t exp_q [$];
    int     expc_q [$];
    int     upd_times [$];
    int     obs_a [4][7];
    int     obs_b [4][7];

    function automatic int el(input logic [MAT_W-1:0] m, input int r, input int c);
        return int'($signed(m[(4*r+c)*DW +: DW]));
    endfunction

    // Reference: expected frames of a whole run from the matrices captured at acceptance.
    task automatic push_run(input logic [MAT_W-1:0] am, input logic [MAT_W-1:0] bm);
        frame_t f;
        int     t, s;
        for (int c = 0; c < RUN_LEN; c++) begin
            f      = '0;
            f.step = -4'sd1;
            if (c == 0) begin
                f.clr = 1'b1;
            end else if (c <= 7) begin
                t      = c - 1;
                f.en   = 2'b11;
                f.step = 4'(t);
                for (int i = 0; i < 4; i++) begin
                    if (t - i >= 0 && t - i <= 3) begin
                        f.a[i*DW +: DW] = DW'(el(am, i, t - i));
                        f.b[i*DW +: DW] = DW'(el(bm, t - i, i));
                    end
                end
            end else if (c < RUN_LEN - 1) begin
                f.en = 2'b11;
            end else begin
                f.upd = 1'b1;
            end
            exp_q.push_back(f);
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += el(am, i, k) * el(bm, k, j);
                expc_q.push_back(s);
            end
        end
    endtask

    // Model: a run occupies RUN_LEN cycles, start is only honoured when no run is pending.
    initial begin
        forever begin
            @(posedge CLK);
            if (RST) begin
                model_cnt = 0;
                exp_q.delete();
                expc_q.delete();
            end else if (model_cnt > 0) begin
                model_cnt--;
            end else if (bus.start) begin
                push_run(bus.a_mat, bus.b_mat);
                model_cnt = RUN_LEN;
            end
        end
    end

    // Monitor: pop and compare while busy; otherwise everything must be quiet.
    initial begin
        frame_t          e;
        logic [4*DW-1:0] act_a, act_b;
        int              s, want, ai, bi;
        forever begin
            @(negedge CLK);
            cyc++;
            if (mon_on) begin
                act_a = {bus.a_in_row3, bus.a_in_row2, bus.a_in_row1, bus.a_in_row0};
                act_b = {bus.b_in_col3, bus.b_in_col2, bus.b_in_col1, bus.b_in_col0};
                if (bus.update_ready === 1'b1) upd_times.push_back(cyc);
                n_vec++;
                if (bus.busy === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_busy cyc=%0d got busy=1 want busy=0", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if ({e.clr, e.en, e.upd, e.a, e.b} !== {bus.clr, bus.enable, bus.update_ready, act_a, act_b}) begin
                            n_err++;
                            $display("FAIL frame cyc=%0d got clr=%b en=%b upd=%b a=%h b=%h want clr=%b en=%b upd=%b a=%h b=%h",
                                     cyc, bus.clr, bus.enable, bus.update_ready, act_a, act_b,
                                     e.clr, e.en, e.upd, e.a, e.b);
                        end
                        if (e.clr) begin
                            obs_a = '{default: 0};
                            obs_b = '{default: 0};
                        end
                        if (e.step >= 0) begin
                            for (int i = 0; i < 4; i++) begin
                                obs_a[i][int'(e.step)] = int'($signed(act_a[i*DW +: DW]));
                                obs_b[i][int'(e.step)] = int'($signed(act_b[i*DW +: DW]));
                            end
                        end
                        if (e.upd) begin
                            for (int i = 0; i < 4; i++) begin
                                for (int j = 0; j < 4; j++) begin
                                    s = 0;
                                    for (int st = 0; st < 13; st++) begin
                                        ai = st - j;
                                        bi = st - i;
                                        if (ai >= 0 && ai <= 6 && bi >= 0 && bi <= 6)
                                            s += obs_a[i][ai] * obs_b[j][bi];
                                    end
                                    want = (expc_q.size() > 0) ? expc_q.pop_front() : 32'h7fff_ffff;
                                    n_vec++;
                                    if (s !== want) begin
                                        n_err++;
                                        $display("FAIL array_c[%0d][%0d] got %0d want %0d", i, j, s, want);
                                    end
                                end
                            end
                        end
                    end
                end else begin
                    if ({bus.busy, bus.clr, bus.enable, bus.update_ready, act_a, act_b} !== '0 || exp_q.size() != 0) begin
                        n_err++;
                        $display("FAIL idle_quiet cyc=%0d got busy=%b clr=%b en=%b upd=%b a=%h b=%h pending=%0d want all 0, pending=0",
                                 cyc, bus.busy, bus.clr, bus.enable, bus.update_ready, act_a, act_b, exp_q.size());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [MAT_W-1:0] rand_mat();
        return MAT_W'({$urandom(), $urandom()});
    endfunction

    // Start pulse, then scribble on the matrix inputs while the run proceeds.
    task automatic run_one(input logic [MAT_W-1:0] am, input logic [MAT_W-1:0] bm);
        bus.a_mat = am;
        bus.b_mat = bm;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < RUN_LEN + 2; c++) begin
            bus.a_mat = rand_mat();
            bus.b_mat = rand_mat();
            tick();
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        logic [MAT_W-1:0] am, bm;
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
        am = '0; bm = '0;
    end

    initial begin
        logic [MAT_W-1:0] am, bm;
        bus.start = 1'b0;
        bus.a_mat = '0;
        bus.b_mat = '0;
        RST       = 1'b1;
        tick();
        mon_on = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        tick();

        // Identity A, ramp B = 4k+j-8.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                am[(4*i+k)*DW +: DW] = (i == k) ? DW'(1) : DW'(0);
                bm[(4*i+k)*DW +: DW] = DW'(4*i + k - 8);
            end
        end
        run_one(am, bm);

        // All ones, then sign extremes.
        run_one({16{4'h1}}, {16{4'h1}});
        run_one({16{4'h8}}, {16{4'h8}});
        run_one({16{4'h7}}, {16{4'h7}});
        run_one({16{4'h8}}, {16{4'h7}});
        run_one({8{8'h78}}, {8{8'h87}});

        for (int r = 0; r < 6; r++) run_one(rand_mat(), rand_mat());

        // start toggling during the run must not launch a second run.
        upd_times.delete();
        bus.a_mat = rand_mat();
        bus.b_mat = rand_mat();
        bus.start = 1'b1;
        tick();
        for (int c = 0; c < 9; c++) begin
            bus.start = ~bus.start;
            tick();
        end
        bus.start = 1'b0;
        repeat (RUN_LEN + 2) tick();
        check_int("toggle_start_upd_count", upd_times.size(), 1);

        // Reset during FEED t=3 aborts the run silently.
        upd_times.delete();
        bus.a_mat = rand_mat();
        bus.b_mat = rand_mat();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        RST       = 1'b1;
        bus.start = 1'b1;
        tick();
        RST       = 1'b0;
        bus.start = 1'b0;
        @(negedge CLK);
        #1;
        check_int("reset_busy", int'(bus.busy), 0);
        repeat (RUN_LEN + 4) tick();
        check_int("reset_upd_count", upd_times.size(), 0);

        // start held high: back-to-back runs, done pulses 14 cycles apart.
        upd_times.delete();
        bus.a_mat = rand_mat();
        bus.b_mat = rand_mat();
        bus.start = 1'b1;
        repeat (30) tick();
        bus.start = 1'b0;
        repeat (20) tick();
        check_int("held_start_upd_count", upd_times.size(), 3);
        if (upd_times.size() >= 3) begin
            check_int("held_start_gap0", upd_times[1] - upd_times[0], 14);
            check_int("held_start_gap1", upd_times[2] - upd_times[1], 14);
        end
        check_int("final_pending_frames", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
